wb_regfile: RTL and testbench

//  Writeback stage + architectural register file of the 16-bit pipeline; sits directly downstream of the MEM/WB buffer.

---
 rtl/cpu_pkg.sv | 37 +++
 rtl/wb_write_decode.sv | 34 +++
 rtl/wb_regfile.sv | 88 ++++++++
 tb/tb_wb_regfile.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared pipeline constants, writeback command encodings and the writeback
// request bundle used by the writeback stage / register file.
package cpu_pkg;

   localparam int DATA_W   = 16;
   localparam int ADDR_W   = 4;
   localparam int NUM_REGS = 1 << ADDR_W;
   localparam logic [ADDR_W-1:0] R15_IDX = 4'd15;

   typedef enum logic [1:0] {
      WB_NONE    = 2'b00,
      WB_OP1     = 2'b01,
      WB_OP1_R15 = 2'b10,
      WB_OP1_OP2 = 2'b11
   } wb_cmd_e;

   // Per-register source of the committed value
   typedef enum logic [1:0] {
      SEL_OP1 = 2'b00,
      SEL_OP2 = 2'b01,
      SEL_R15 = 2'b10
   } wb_sel_e;

   typedef struct packed {
      wb_cmd_e             cmd;
      logic [ADDR_W-1:0]   op1;
      logic [ADDR_W-1:0]   op2;
      logic [DATA_W-1:0]   op1data;
      logic [DATA_W-1:0]   op2data;
      logic [DATA_W-1:0]   r15data;
   } wb_req_t;

   function automatic logic wb_active(input wb_cmd_e cmd);
      return cmd != WB_NONE;
   endfunction

endpackage

// File: rtl/wb_write_decode.sv
// Combinational writeback decode: per-register write enable and data select
// with same-target precedence (r15data over op1, op2data over op1).
import cpu_pkg::*;

module wb_write_decode #(
   parameter int ADDR_W   = cpu_pkg::ADDR_W,
   parameter int NUM_REGS = cpu_pkg::NUM_REGS
) (
   input  wb_cmd_e                     cmd,
   input  logic [ADDR_W-1:0]           op1,
   input  logic [ADDR_W-1:0]           op2,
   output logic [NUM_REGS-1:0]         we,
   output wb_sel_e [NUM_REGS-1:0]      sel
);

   for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
      logic hit1, hit2, hitr;

      always_comb begin
         hit1 = wb_active(cmd) && (op1 == ADDR_W'(i));
         hit2 = (cmd == WB_OP1_OP2) && (op2 == ADDR_W'(i));
         hitr = (cmd == WB_OP1_R15) && (R15_IDX == ADDR_W'(i));
         we[i] = hit1 | hit2 | hitr;
         // op2 and r15 paths are mutually exclusive by command, both outrank op1
         if (hitr)
            sel[i] = SEL_R15;
         else if (hit2)
            sel[i] = SEL_OP2;
         else
            sel[i] = SEL_OP1;
      end
   end

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage and 16x16 architectural register file with two async read
// ports, an r15 tap and a retired-writeback counter. Define WB_BYPASS_EN for
// same-cycle write-through forwarding onto the read ports.
import cpu_pkg::*;

module wb_regfile #(
   parameter int DATA_W   = cpu_pkg::DATA_W,
   parameter int ADDR_W   = cpu_pkg::ADDR_W,
   parameter int NUM_REGS = cpu_pkg::NUM_REGS
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [1:0]          rWrite,
   input  logic [ADDR_W-1:0]   op1,
   input  logic [ADDR_W-1:0]   op2,
   input  logic [DATA_W-1:0]   op1data,
   input  logic [DATA_W-1:0]   op2data,
   input  logic [DATA_W-1:0]   r15data,
   input  logic [ADDR_W-1:0]   rdAddrA,
   input  logic [ADDR_W-1:0]   rdAddrB,
   output logic [DATA_W-1:0]   rdDataA,
   output logic [DATA_W-1:0]   rdDataB,
   output logic [DATA_W-1:0]   r15Out,
   output logic [15:0]         wbCount
);

   wb_req_t                           req;
   logic [NUM_REGS-1:0]               we;
   wb_sel_e [NUM_REGS-1:0]            sel;
   logic [NUM_REGS-1:0][DATA_W-1:0]   regs;
   logic [NUM_REGS-1:0][DATA_W-1:0]   wdata;
   logic [NUM_REGS-1:0][DATA_W-1:0]   rd_view;

   always_comb begin
      req.cmd     = wb_cmd_e'(rWrite);
      req.op1     = op1;
      req.op2     = op2;
      req.op1data = op1data;
      req.op2data = op2data;
      req.r15data = r15data;
   end

   wb_write_decode #(
      .ADDR_W   (ADDR_W),
      .NUM_REGS (NUM_REGS)
   ) u_dec (
      .cmd (req.cmd),
      .op1 (req.op1),
      .op2 (req.op2),
      .we  (we),
      .sel (sel)
   );

   for (genvar i = 0; i < NUM_REGS; i++) begin : g_wdata
      always_comb begin
         unique case (sel[i])
            SEL_OP2: wdata[i] = req.op2data;
            SEL_R15: wdata[i] = req.r15data;
            default: wdata[i] = req.op1data;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         regs    <= '0;
         wbCount <= '0;
      end else begin
         for (int i = 0; i < NUM_REGS; i++)
            if (we[i]) regs[i] <= wdata[i];
         if (wb_active(req.cmd)) wbCount <= wbCount + 16'd1;
      end
   end

`ifdef WB_BYPASS_EN
   // Forward only what will actually commit, so nothing leaks during reset
   for (genvar i = 0; i < NUM_REGS; i++) begin : g_byp
      assign rd_view[i] = (we[i] && !rst) ? wdata[i] : regs[i];
   end
`else
   assign rd_view = regs;
`endif

   assign rdDataA = rd_view[rdAddrA];
   assign rdDataB = rd_view[rdAddrB];
   assign r15Out  = rd_view[R15_IDX];

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: directed writebacks push hand-computed read
// expectations; a negedge monitor pops and compares them.
import cpu_pkg::*;

module tb_wb_regfile;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  rWrite;
   logic [3:0]  op1, op2, rdAddrA, rdAddrB;
   logic [15:0] op1data, op2data, r15data;
   logic [15:0] rdDataA, rdDataB, r15Out, wbCount;
   logic        chk;

   int checks = 0;
   int errors = 0;

`ifdef WB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   typedef struct {
      string       nm;
      logic [15:0] a, b, r, c;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   wb_regfile dut (
      .clk     (clk),
      .rst     (rst),
      .rWrite  (rWrite),
      .op1     (op1),
      .op2     (op2),
      .op1data (op1data),
      .op2data (op2data),
      .r15data (r15data),
      .rdAddrA (rdAddrA),
      .rdAddrB (rdAddrB),
      .rdDataA (rdDataA),
      .rdDataB (rdDataB),
      .r15Out  (r15Out),
      .wbCount (wbCount)
   );

   task automatic cmp(input string nm, input string fld, input logic [15:0] act, input logic [15:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s.%s: got 0x%04h, expected 0x%04h", nm, fld, act, req);
      end
   endtask

   // Monitor: read outputs are valid mid-cycle whenever the stimulus flags a check
   always @(negedge clk) begin
      if (chk) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard: check strobe with empty queue at %0t", $time);
         end else begin
            exp_t e;
            e = sb.pop_front();
            cmp(e.nm, "rdDataA", rdDataA, e.a);
            cmp(e.nm, "rdDataB", rdDataB, e.b);
            cmp(e.nm, "r15Out",  r15Out,  e.r);
            cmp(e.nm, "wbCount", wbCount, e.c);
         end
      end
   end

   task automatic cyc(input logic r, input logic [1:0] rw,
                      input logic [3:0] o1, input logic [3:0] o2,
                      input logic [15:0] d1, input logic [15:0] d2, input logic [15:0] rd,
                      input logic [3:0] ra, input logic [3:0] rb, input logic c);
      @(posedge clk);
      #1;
      rst = r; rWrite = rw; op1 = o1; op2 = o2;
      op1data = d1; op2data = d2; r15data = rd;
      rdAddrA = ra; rdAddrB = rb; chk = c;
   endtask

   task automatic expect_rd(input string nm, input logic [15:0] a, input logic [15:0] b,
                            input logic [15:0] r, input logic [15:0] c);
      exp_t e;
      e.nm = nm; e.a = a; e.b = b; e.r = r; e.c = c;
      sb.push_back(e);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; rWrite = WB_NONE; op1 = '0; op2 = '0;
      op1data = '0; op2data = '0; r15data = '0;
      rdAddrA = '0; rdAddrB = '0; chk = 1'b0;
      cyc(1, WB_NONE, 0, 0, 16'h0, 16'h0, 16'h0, 0, 0, 0);

      // Dirty the file, then reset with a write presented in the reset cycle
      cyc(0, WB_OP1,     3, 0, 16'h1111, 16'h0, 16'h0,    0, 0, 0);
      cyc(0, WB_OP1_R15, 1, 0, 16'h0002, 16'h0, 16'h0003, 0, 0, 0);
      cyc(1, WB_OP1,     4, 0, 16'h9999, 16'h0, 16'h0,    0, 0, 0);
      for (int i = 0; i < 8; i++) begin
         cyc(0, WB_NONE, 0, 0, 16'h0, 16'h0, 16'h0, 4'(i), 4'(15 - i), 1);
         expect_rd($sformatf("reset_r%0d", i), 16'h0, 16'h0, 16'h0, 16'h0);
      end

      // WB_OP1, same-cycle read then committed read
      cyc(0, WB_OP1, 3, 0, 16'hBEEF, 16'h0, 16'h0, 3, 4, 1);
      expect_rd("op1_samecyc", BYP ? 16'hBEEF : 16'h0000, 16'h0, 16'h0, 16'd0);
      cyc(0, WB_NONE, 0, 0, 16'h0, 16'h0, 16'h0, 3, 4, 1);
      expect_rd("op1_commit", 16'hBEEF, 16'h0, 16'h0, 16'd1);

      // WB_OP1_R15, distinct targets then op1 == 15
      cyc(0, WB_OP1_R15, 2, 0, 16'h1234, 16'h0, 16'h00FF, 0, 0, 0);
      cyc(0, WB_NONE, 0, 0, 16'h0, 16'h0, 16'h0, 2, 15, 1);
      expect_rd("op1_r15", 16'h1234, 16'h00FF, 16'h00FF, 16'd2);
      cyc(0, WB_OP1_R15, 15, 0, 16'hAAAA, 16'h0, 16'h7777, 0, 0, 0);
      cyc(0, WB_NONE, 0, 0, 16'h0, 16'h0, 16'h0, 15, 2, 1);
      expect_rd("r15_conflict", 16'h7777, 16'h1234, 16'h7777, 16'd3);

      // WB_OP1_OP2, distinct targets then op1 == op2
      cyc(0, WB_OP1_OP2, 5, 6, 16'hAAAA, 16'h5555, 16'h0, 0, 0, 0);
      cyc(0, WB_NONE, 0, 0, 16'h0, 16'h0, 16'h0, 5, 6, 1);
      expect_rd("op1_op2", 16'hAAAA, 16'h5555, 16'h7777, 16'd4);
      cyc(0, WB_OP1_OP2, 7, 7, 16'h1111, 16'h5555, 16'h0, 0, 0, 0);
      cyc(0, WB_NONE, 0, 0, 16'h0, 16'h0, 16'h0, 7, 5, 1);
      expect_rd("op2_conflict", 16'h5555, 16'hAAAA, 16'h7777, 16'd5);

      // op2 / r15data must be ignored under plain WB_OP1
      cyc(0, WB_OP1, 8, 6, 16'h0808, 16'hFFFF, 16'hFFFF, 0, 0, 0);
      cyc(0, WB_NONE, 0, 0, 16'h0, 16'h0, 16'h0, 8, 6, 1);
      expect_rd("op1_ignores", 16'h0808, 16'h5555, 16'h7777, 16'd6);

      // Same-cycle write/read hazard
      cyc(0, WB_OP1, 9, 0, 16'h0001, 16'h0, 16'h0, 0, 0, 0);
      cyc(0, WB_OP1, 9, 0, 16'h0C0C, 16'h0, 16'h0, 0, 9, 1);
      expect_rd("hazard_b", 16'h0, BYP ? 16'h0C0C : 16'h0001, 16'h7777, 16'd7);
      cyc(0, WB_OP1_R15, 15, 0, 16'h0001, 16'h0, 16'hABCD, 15, 9, 1);
      expect_rd("hazard_r15", BYP ? 16'hABCD : 16'h7777, 16'h0C0C,
                BYP ? 16'hABCD : 16'h7777, 16'd8);
      cyc(0, WB_OP1_OP2, 10, 10, 16'h0001, 16'h0002, 16'h0, 10, 11, 1);
      expect_rd("hazard_op2", BYP ? 16'h0002 : 16'h0000, 16'h0, 16'hABCD, 16'd9);
      cyc(0, WB_NONE, 0, 0, 16'h0, 16'h0, 16'h0, 9, 10, 1);
      expect_rd("hazard_commit", 16'h0C0C, 16'h0002, 16'hABCD, 16'd10);

      // Reset mid-operation drops the in-flight write; next command commits
      cyc(1, WB_OP1, 9, 0, 16'hFFFF, 16'h0, 16'h0, 0, 0, 0);
      cyc(0, WB_NONE, 0, 0, 16'h0, 16'h0, 16'h0, 9, 15, 1);
      expect_rd("midrst", 16'h0, 16'h0, 16'h0, 16'd0);
      cyc(0, WB_OP1, 9, 0, 16'h4242, 16'h0, 16'h0, 0, 0, 0);
      cyc(0, WB_NONE, 0, 0, 16'h0, 16'h0, 16'h0, 9, 10, 1);
      expect_rd("post_rst", 16'h4242, 16'h0, 16'h0, 16'd1);

      // Counter wrap: 1 + 65534 = 0xFFFF, then one more wraps to 0
      for (int i = 0; i < 65534; i++)
         cyc(0, WB_OP1, 0, 0, 16'h0, 16'h0, 16'h0, 9, 15, 0);
      cyc(0, WB_NONE, 0, 0, 16'h0, 16'h0, 16'h0, 9, 15, 1);
      expect_rd("cnt_ffff", 16'h4242, 16'h0, 16'h0, 16'hFFFF);
      cyc(0, WB_NONE, 0, 0, 16'h0, 16'h0, 16'h0, 9, 15, 1);
      expect_rd("cnt_hold", 16'h4242, 16'h0, 16'h0, 16'hFFFF);
      cyc(0, WB_OP1, 1, 0, 16'h0101, 16'h0, 16'h0, 9, 15, 1);
      expect_rd("cnt_last", 16'h4242, 16'h0, 16'h0, 16'hFFFF);
      cyc(0, WB_NONE, 0, 0, 16'h0, 16'h0, 16'h0, 1, 9, 1);
      expect_rd("cnt_wrap", 16'h0101, 16'h4242, 16'h0, 16'h0000);

      cyc(0, WB_NONE, 0, 0, 16'h0, 16'h0, 16'h0, 0, 0, 0);
      @(posedge clk);
      @(posedge clk);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
